// File: rtl/branch_pkg.sv
// Shared branch definitions: func3 encodings, BHT counter states and the
// saturating counter update used by the branch predict unit.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_cnt_t;

  // Two-bit saturating counter step: taken moves toward ST, not taken toward SNT.
  function automatic bht_cnt_t sat_update(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t next;
    next = cnt;
    if (taken) begin
      if (cnt != ST) next = bht_cnt_t'(cnt + 2'd1);
    end else begin
      if (cnt != SNT) next = bht_cnt_t'(cnt - 2'd1);
    end
    return next;
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch/jump resolution from func3 and the ALU less/zero flags.
// o_legal marks the func3 encodings that are real conditional branches.
module branch_resolve
  import branch_pkg::*;
(
  input  logic       i_jump,
  input  logic       i_branch,
  input  logic [2:0] i_func3,
  input  logic       i_less,
  input  logic       i_zero,
  output logic       o_taken,
  output logic       o_legal
);

  logic w_cond;

  always_comb begin
    w_cond  = 1'b0;
    o_legal = 1'b1;
    case (i_func3)
      F3_BEQ:          w_cond = i_zero;
      F3_BNE:          w_cond = ~i_zero;
      F3_BLT, F3_BLTU: w_cond = i_less;
      F3_BGE, F3_BGEU: w_cond = ~i_less | i_zero;
      default: begin
        w_cond  = 1'b0;
        o_legal = 1'b0;
      end
    endcase
  end

  // Jumps always redirect and take priority over any branch encoding.
  assign o_taken = i_jump | (i_branch & w_cond);

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: EX-stage resolution plus a PC-indexed BHT of 2-bit
// counters feeding IF. Define BPU_PERF_CNT_EN to add branch/mispredict counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] BHT_INIT    = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_predict_taken,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic [2:0]      ex_func3,
  input  logic            ex_less,
  input  logic            ex_zero,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  output logic            pc_sel,
  output logic            mispredict
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  bht_cnt_t r_bht [BHT_ENTRIES];

  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic             w_active;
  logic             w_taken;
  logic             w_legal;
  logic             w_update;
  logic             w_unused;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_unused = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  branch_resolve u_resolve (
    .i_jump   (ex_jump),
    .i_branch (ex_branch),
    .i_func3  (ex_func3),
    .i_less   (ex_less),
    .i_zero   (ex_zero),
    .o_taken  (w_taken),
    .o_legal  (w_legal)
  );

  assign w_active   = ex_valid & ~ex_stall;
  assign pc_sel     = w_active & w_taken;
  assign mispredict = w_active & (ex_branch | ex_jump) & (w_taken != ex_pred_taken);

  // Read is straight from the array, so a same-cycle update is seen next cycle.
  assign if_predict_taken = r_bht[w_if_idx][1];

  assign w_update = w_active & ex_branch & ~ex_jump & w_legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= bht_cnt_t'(BHT_INIT);
      end
    end else if (w_update) begin
      r_bht[w_ex_idx] <= sat_update(r_bht[w_ex_idx], w_taken);
    end
  end

`ifdef BPU_PERF_CNT_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispredicts;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_branches    <= 32'd0;
      r_perf_mispredicts <= 32'd0;
    end else begin
      if (w_active & (ex_branch | ex_jump)) r_perf_branches <= r_perf_branches + 32'd1;
      if (mispredict) r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
    end
  end

  assign perf_branches    = r_perf_branches;
  assign perf_mispredicts = r_perf_mispredicts;
`endif

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Successor to the single-cycle branch condition decoder: resolves branch/jump conditions in EX and adds a PC-indexed branch history table (BHT) of 2-bit saturating counters that supplies a taken prediction to IF.
- Flags EX-stage mispredictions so the pipeline can redirect and flush.
- Sits between the IF fetch logic and the EX-stage ALU compare outputs of the pipelined core.

Parameters:
- XLEN, 32, width of PC values.
- BHT_ENTRIES, 64, number of 2-bit counters; must be a power of two, minimum 2.
- BHT_INIT, 2'b01, counter value loaded on reset (weakly not-taken).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- if_pc  input  XLEN  PC of the instruction being fetched.
- if_predict_taken  output  1  BHT prediction for if_pc (combinational read).
- ex_valid  input  1  EX stage holds a valid instruction.
- ex_stall  input  1  EX stage held; suppresses the BHT update and the mispredict output.
- ex_branch  input  1  EX instruction is a conditional branch.
- ex_jump  input  1  EX instruction is jal/jalr.
- ex_func3  input  3  branch func3.
- ex_less  input  1  rs1 < rs2; signed or unsigned per func3, computed by the ALU.
- ex_zero  input  1  rs1 == rs2.
- ex_pc  input  XLEN  PC of the EX instruction.
- ex_pred_taken  input  1  prediction carried down the pipe with this instruction.
- pc_sel  output  1  actual outcome; 1 = branch/jump taken.
- mispredict  output  1  actual outcome differs from ex_pred_taken; 1 = redirect and flush.

Behaviour:
- Index width IDX_W = log2(BHT_ENTRIES). IF index = if_pc[IDX_W+1:2]; EX index = ex_pc[IDX_W+1:2]. PC bits [1:0] are ignored.
- Prediction: if_predict_taken = bht[IF index][1]. It is asynchronous and registered nowhere in this block.
- Resolution (combinational), active = ex_valid & !ex_stall:
  - ex_jump: taken = 1. ex_jump has priority over ex_branch.
  - ex_branch with func3 000 (beq): taken = zero.
  - 001 (bne): taken = !zero.
  - 100 (blt) and 110 (bltu): taken = less.
  - 101 (bge) and 111 (bgeu): taken = !less | zero.
  - 010 and 011: taken = 0.
  - Neither ex_jump nor ex_branch: taken = 0.
- pc_sel = active & taken.
- mispredict = active & (ex_branch | ex_jump) & (taken != ex_pred_taken).
- BHT update, on the rising edge when active & ex_branch & !ex_jump & func3 is legal:
  - Taken: counter = min(counter+1, 3).
  - Not taken: counter = max(counter-1, 0).
  - Jumps and illegal func3 never update the BHT.
- Read/write same index in the same cycle: if_predict_taken returns the pre-update value; there is no bypass.
- Reset: every counter is loaded with BHT_INIT in one cycle.
  - pc_sel and mispredict follow their inputs (both 0 when ex_valid = 0).
  - if_predict_taken = BHT_INIT[1] (0 by default) one cycle after reset asserts.
  - A reset asserted in the same cycle as an update wins; the update is discarded.
- Latency: resolution is 0 cycles; the BHT update is visible 1 cycle later.

Optional Feature:
- Macro: BPU_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_branches [31:0]: increments on every active & (ex_branch | ex_jump).
  - perf_mispredicts [31:0]: increments on every mispredict.
  - Both wrap from 0xFFFFFFFF to 0 and clear on reset.
- When undefined, the ports and counters are absent and the core behaviour is unchanged.

Decomposition:
- Package branch_pkg holds:
  - func3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - typedef bht_cnt_t as a 2-bit enum: SNT = 0, WNT = 1, WT = 2, ST = 3.
  - function sat_update(bht_cnt_t, logic taken).
- One natural sub-module, branch_resolve: the purely combinational func3/less/zero/jump evaluation producing taken. The BHT array and its update logic stay in the top module.

Test Plan:
- Reset, then sweep if_pc = 0x0..0xFC -> if_predict_taken = 0 for all 64 indices.
- ex_pc = 0x40, beq, zero = 1, ex_pred_taken = 0, for three consecutive cycles:
  - pc_sel = 1 and mispredict = 1 each cycle.
  - At if_pc = 0x40 the counter steps 01 -> 10 -> 11 -> 11 (saturates); prediction becomes 1 after the first update.
- bge with less = 1, zero = 1 -> pc_sel = 1. Then bgeu with less = 1, zero = 0 -> pc_sel = 0.
- jal, ex_pred_taken = 0 -> pc_sel = 1, mispredict = 1, BHT entry for ex_pc unchanged.
- func3 = 010 with ex_branch = 1 -> pc_sel = 0, no update.
- ex_stall = 1 with beq taken -> pc_sel = 0, mispredict = 0, counter unchanged.
- ex_pc = 0x04 and ex_pc = 0x104 alias to the same index -> both update the same counter.
- Same-cycle read/write: if_pc = ex_pc = 0x08 with a taken update -> if_predict_taken shows the old value, then the new value next cycle.
- BPU_PERF_CNT_EN: preload perf_branches = 0xFFFFFFFF via force, issue one branch -> wraps to 0.
